// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master issues start/hold/abort
// requests, the slave (the timer) returns the registered count and state flags.
interface countdown_timer_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, hold, abort,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, hold, abort,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with hold and abort: IDLE -> RUN (N cycles) -> one-cycle DONE.
// busy/done are pure state decodes; count is a register that never wraps below zero.
module countdown_timer #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             load_zero;

  assign load_zero = (bus.load_val == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the async reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: next-state values default to "hold" before any branch, so no path
  // leaves a combinational output unassigned (no inferred latch).
  always_comb begin
    state_d = state_q;
    count_d = count_q;

    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE, giving back-to-back runs.
        IDLE, DONE: begin
          if (bus.start) begin
            if (load_zero) begin
              state_d = DONE;
              count_d = '0;
            end else begin
              state_d = RUN;
              count_d = bus.load_val;
            end
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end

        RUN: begin
          if (!bus.hold) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              state_d = DONE;
              count_d = '0;
            end
          end
        end

        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

  // Structural invariants of the state/count pairing.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst)
    !(bus.busy && bus.done));

  a_run_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RUN) |-> (count_q != '0));

  a_done_zero: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE) |-> (count_q == '0));

  a_no_count_up: assert property (@(posedge clk) disable iff (!rst)
    (state_q == RUN) |=> (count_q <= $past(count_q)));

endmodule
